// File: rtl/rpn_stack_pkg.sv
// Shared types and helpers for the RPN operand stack.
package rpn_stack_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRefill1,
        StRefill2
    } state_e;

    localparam logic [1:0] ERR_UNF = 2'b01;
    localparam logic [1:0] ERR_OVF = 2'b10;

    // Number of RAM reads needed to restore the two cache registers after a
    // legal operation on a stack of c entries popping p and pushing w.
    function automatic logic [1:0] refill_cnt(input int unsigned c, input logic [1:0] p,
                                              input logic w);
        logic [1:0] k;
        k = 2'd0;
        case ({p, w})
            3'b010, 3'b101: k = (c >= 3) ? 2'd1 : 2'd0;
            3'b100:         k = (c >= 4) ? 2'd2 : ((c >= 3) ? 2'd1 : 2'd0);
            default:        k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/rpn_stack_ram.sv
// Backing store for stack entries below the two cache registers.
// One synchronous write port, one synchronous read port (1-cycle latency, no reset).
module rpn_stack_ram
    import rpn_stack_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port, address sampled every cycle.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rpn_stack.sv
// RPN operand stack: top two entries cached in registers, the rest in RAM.
// Optional feature macro RPN_STACK_HWM_EN adds a high-water-mark output hwm_o.
module rpn_stack
    import rpn_stack_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [1:0]        pop_cnt_i,
    input  logic              wen_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] first_o,
    output logic [DATA_W-1:0] second_o,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    input  logic              err_clr_i
`ifdef RPN_STACK_HWM_EN
    ,
    output logic [ADDR_W:0]   hwm_o
`endif
);

    localparam logic [ADDR_W+1:0] DepthExt = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    logic              op_ready_q;
    logic              tgt_first_q;
    logic [DATA_W-1:0] first_q, second_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              accept, unf, ovf, legal;
    logic [ADDR_W+1:0] count_ext, next_ext;
    logic [1:0]        k;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    // Operation decode, error detection and next count / error state.
    always_comb begin
        accept    = op_valid_i && op_ready_q;
        count_ext = {1'b0, count_q};
        next_ext  = count_ext - {{ADDR_W{1'b0}}, pop_cnt_i} + {{(ADDR_W + 1){1'b0}}, wen_i};
        unf       = (pop_cnt_i == 2'd3) || ({{ADDR_W{1'b0}}, pop_cnt_i} > count_ext);
        // next_ext wraps on underflow, so only trust it when popping is legal
        ovf       = !unf && (next_ext > DepthExt);
        legal     = accept && !unf && !ovf;
        k         = legal ? refill_cnt(32'(count_q), pop_cnt_i, wen_i) : 2'd0;
        count_d   = legal ? next_ext[ADDR_W:0] : count_q;

        // A new error in the same cycle as a clear wins.
        err_code_d = err_clr_i ? 2'b00 : err_code_q;
        if (accept && unf) err_code_d = err_code_d | ERR_UNF;
        if (accept && ovf) err_code_d = err_code_d | ERR_OVF;
    end

    // RAM port addressing; modular arithmetic on the low bits is exact since
    // illegal operations never reach the RAM.
    always_comb begin
        ram_we    = legal && (pop_cnt_i == 2'd0) && wen_i && (count_q >= (ADDR_W + 1)'(2));
        ram_waddr = count_q[ADDR_W-1:0] - ADDR_W'(2);
        // In StRefill2 count_q already holds c-2, so c-4 is count_q-2.
        ram_raddr = (state_q == StRefill2) ? count_q[ADDR_W-1:0] - ADDR_W'(2)
                                           : count_q[ADDR_W-1:0] - ADDR_W'(3);
    end

    rpn_stack_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (second_q),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Control FSM, cache registers, count and sticky error state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            op_ready_q  <= 1'b1;
            tgt_first_q <= 1'b0;
            first_q     <= '0;
            second_q    <= '0;
            count_q     <= '0;
            err_code_q  <= 2'b00;
        end else begin
            count_q    <= count_d;
            err_code_q <= err_code_d;
            unique case (state_q)
                StIdle: begin
                    if (legal) begin
                        case ({pop_cnt_i, wen_i})
                            3'b001: begin
                                second_q <= first_q;
                                first_q  <= din_i;
                            end
                            3'b011, 3'b101: first_q <= din_i;
                            3'b010:         first_q <= second_q;
                            default: ;
                        endcase
                        // A lone refill after pop-2 restores first, otherwise second.
                        tgt_first_q <= (pop_cnt_i == 2'd2) && !wen_i && (k == 2'd1);
                        state_q     <= (k == 2'd2) ? StRefill2 :
                                       (k == 2'd1) ? StRefill1 : StIdle;
                        op_ready_q  <= (k == 2'd0);
                    end
                end
                StRefill2: begin
                    first_q     <= ram_rdata;
                    tgt_first_q <= 1'b0;
                    state_q     <= StRefill1;
                end
                StRefill1: begin
                    if (tgt_first_q) begin
                        first_q <= ram_rdata;
                    end else begin
                        second_q <= ram_rdata;
                    end
                    state_q    <= StIdle;
                    op_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= StIdle;
                    op_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef RPN_STACK_HWM_EN
    logic [ADDR_W:0] hwm_q, hwm_d;

    // High-water mark follows count_d; a clear restarts it from the new count.
    always_comb begin
        hwm_d = err_clr_i ? '0 : hwm_q;
        if (count_d > hwm_d) hwm_d = count_d;
    end

    // High-water mark register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm_o = hwm_q;
`endif

    // Slots without a logical entry read as zero.
    assign first_o    = (count_q == '0) ? '0 : first_q;
    assign second_o   = (count_q < (ADDR_W + 1)'(2)) ? '0 : second_q;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DepthCnt);
    assign err_code_o = err_code_q;
    assign err_o      = |err_code_q;
    assign op_ready_o = op_ready_q;

endmodule

// File: tb/tb_rpn_stack.sv
// Self-checking bench for rpn_stack: directed table, corner sequences, random ops.
module tb_rpn_stack;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int DEP = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [1:0]    pop_cnt = 2'd0;
    logic          wen = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] first, second;
    logic [AW:0]   count;
    logic          empty, full, err;
    logic [1:0]    err_code;
    logic          err_clr = 1'b0;
`ifdef RPN_STACK_HWM_EN
    logic [AW:0]   hwm;
`endif

    rpn_stack #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .op_valid_i (op_valid),
        .op_ready_o (op_ready),
        .pop_cnt_i  (pop_cnt),
        .wen_i      (wen),
        .din_i      (din),
        .first_o    (first),
        .second_o   (second),
        .count_o    (count),
        .empty_o    (empty),
        .full_o     (full),
        .err_o      (err),
        .err_code_o (err_code),
        .err_clr_i  (err_clr)
`ifdef RPN_STACK_HWM_EN
        ,
        .hwm_o      (hwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] f;
        logic [DW-1:0] s;
        int            c;
        logic [1:0]    ec;
        int            low;
    } exp_t;

    typedef struct {
        logic [1:0]    p;
        logic          w;
        logic [DW-1:0] d;
        exp_t          e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Reference stack: index 0 is the bottom.
    logic [DW-1:0] stk[$];
    logic [1:0]    m_err;
    int            m_hwm;

    function automatic vec_t mk(input logic [1:0] p, input logic w, input logic [DW-1:0] d,
                                input logic [DW-1:0] f, input logic [DW-1:0] s, input int c,
                                input logic [1:0] ec, input int low);
        vec_t v;
        v.p = p; v.w = w; v.d = d;
        v.e.f = f; v.e.s = s; v.e.c = c; v.e.ec = ec; v.e.low = low;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_state(input string tag, input exp_t e);
        check({tag, ".first"}, 32'(first), 32'(e.f));
        check({tag, ".second"}, 32'(second), 32'(e.s));
        check({tag, ".count"}, 32'(count), e.c);
        check({tag, ".empty"}, 32'(empty), 32'(e.c == 0));
        check({tag, ".full"}, 32'(full), 32'(e.c == DEP));
        check({tag, ".err_code"}, 32'(err_code), 32'(e.ec));
        check({tag, ".err"}, 32'(err), 32'(|e.ec));
    endtask

    // Drive one operation at posedge+1, then wait (bounded) for op_ready and score it.
    task automatic run_op(input logic [1:0] p, input logic w, input logic [DW-1:0] d,
                          input logic clr, input exp_t e, input string tag);
        int   low;
        exp_t got;
        sb.push_back(e);
        op_valid = 1'b1; pop_cnt = p; wen = w; din = d; err_clr = clr;
        @(posedge clk); #1;
        op_valid = 1'b0; pop_cnt = 2'd0; wen = 1'b0; err_clr = 1'b0;
        low = 0;
        while (!op_ready && low < 8) begin
            @(posedge clk); #1;
            low++;
        end
        got = sb.pop_front();
        check({tag, ".ready_low"}, low, got.low);
        compare_state(tag, got);
    endtask

    function automatic exp_t model_step(input logic [1:0] p, input logic w,
                                        input logic [DW-1:0] d, input logic clr);
        exp_t e;
        int   c;
        int   k;
        c = stk.size();
        k = 0;
        if (clr) begin
            m_err = 2'b00;
            m_hwm = 0;
        end
        if (p == 2'd3 || int'(p) > c) begin
            m_err = m_err | 2'b01;
        end else if (c - int'(p) + int'(w) > DEP) begin
            m_err = m_err | 2'b10;
        end else begin
            if ((p == 2'd1 && !w) || (p == 2'd2 && w)) k = (c >= 3) ? 1 : 0;
            else if (p == 2'd2 && !w) k = (c >= 4) ? 2 : ((c >= 3) ? 1 : 0);
            for (int i = 0; i < int'(p); i++) void'(stk.pop_back());
            if (w) stk.push_back(d);
        end
        if (stk.size() > m_hwm) m_hwm = stk.size();
        e.f   = (stk.size() > 0) ? stk[stk.size() - 1] : '0;
        e.s   = (stk.size() > 1) ? stk[stk.size() - 2] : '0;
        e.c   = stk.size();
        e.ec  = m_err;
        e.low = k;
        return e;
    endfunction

    task automatic mop(input logic [1:0] p, input logic w, input logic [DW-1:0] d,
                       input logic clr, input string tag);
        exp_t e;
        e = model_step(p, w, d, clr);
        run_op(p, w, d, clr, e, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[13];

    initial begin
        exp_t rst_e;
        logic [1:0]    rp;
        logic          rw, rc;
        int            r;

        // Directed vectors from a reset stack.
        vecs[0]  = mk(2'd0, 1'b1, 16'd5,  16'd5,  16'd0, 1, 2'b00, 0);
        vecs[1]  = mk(2'd0, 1'b1, 16'd7,  16'd7,  16'd5, 2, 2'b00, 0);
        vecs[2]  = mk(2'd0, 1'b1, 16'd9,  16'd9,  16'd7, 3, 2'b00, 0);
        vecs[3]  = mk(2'd2, 1'b1, 16'd16, 16'd16, 16'd5, 2, 2'b00, 1);
        vecs[4]  = mk(2'd2, 1'b0, 16'd0,  16'd0,  16'd0, 0, 2'b00, 0);
        vecs[5]  = mk(2'd0, 1'b1, 16'd1,  16'd1,  16'd0, 1, 2'b00, 0);
        vecs[6]  = mk(2'd0, 1'b1, 16'd2,  16'd2,  16'd1, 2, 2'b00, 0);
        vecs[7]  = mk(2'd0, 1'b1, 16'd3,  16'd3,  16'd2, 3, 2'b00, 0);
        vecs[8]  = mk(2'd0, 1'b1, 16'd4,  16'd4,  16'd3, 4, 2'b00, 0);
        vecs[9]  = mk(2'd2, 1'b0, 16'd0,  16'd2,  16'd1, 2, 2'b00, 2);
        vecs[10] = mk(2'd1, 1'b0, 16'd0,  16'd1,  16'd0, 1, 2'b00, 0);
        vecs[11] = mk(2'd1, 1'b0, 16'd0,  16'd0,  16'd0, 0, 2'b00, 0);
        vecs[12] = mk(2'd1, 1'b0, 16'd0,  16'd0,  16'd0, 0, 2'b01, 0);

        repeat (2) @(posedge clk);
        #1;
        rst_e.f = '0; rst_e.s = '0; rst_e.c = 0; rst_e.ec = 2'b00; rst_e.low = 0;
        compare_state("reset", rst_e);
        check("reset.op_ready", 32'(op_ready), 32'd1);
`ifdef RPN_STACK_HWM_EN
        check("reset.hwm", 32'(hwm), 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].p, vecs[i].w, vecs[i].d, 1'b0, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Model now tracks the DUT: empty, underflow latched, peak 4.
        stk.delete();
        m_err = 2'b01;
        m_hwm = 4;

        // Clear racing a fresh underflow keeps the error; clear alone drops it.
        mop(2'd1, 1'b0, 16'd0, 1'b1, "unf_clr");
        mop(2'd0, 1'b0, 16'd0, 1'b1, "clr");
        mop(2'd0, 1'b1, 16'h11, 1'b0, "push11");
        mop(2'd3, 1'b0, 16'd0, 1'b0, "pop3");
        mop(2'd1, 1'b0, 16'd0, 1'b1, "clr_pop");

        // Fill to full, overflow, then pop-2/push-1 at full.
        for (int i = 1; i <= DEP; i++) mop(2'd0, 1'b1, 16'(i), 1'b0, $sformatf("fill%0d", i));
        mop(2'd0, 1'b1, 16'd99, 1'b0, "ovf");
        check("ovf.count_const", 32'(count), 32'd32);
        check("ovf.code_const", 32'(err_code), 32'd2);
        mop(2'd2, 1'b1, 16'd100, 1'b0, "p2w1_full");
        check("p2w1_full.count_const", 32'(count), 32'd31);
        check("p2w1_full.second_const", 32'(second), 32'd30);
`ifdef RPN_STACK_HWM_EN
        check("fill.hwm", 32'(hwm), 32'd32);
`endif
        for (int i = 0; i < 31; i++) mop(2'd1, 1'b0, 16'd0, 1'b0, $sformatf("drain%0d", i));

        // Reset while two refills are pending.
        for (int i = 1; i <= 4; i++) mop(2'd0, 1'b1, 16'(i), 1'b1, $sformatf("pre%0d", i));
        op_valid = 1'b1; pop_cnt = 2'd2; wen = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0; pop_cnt = 2'd0;
        check("rst_refill.busy", 32'(op_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        compare_state("rst_refill", rst_e);
        check("rst_refill.op_ready", 32'(op_ready), 32'd1);
`ifdef RPN_STACK_HWM_EN
        check("rst_refill.hwm", 32'(hwm), 32'd0);
`endif
        stk.delete();
        m_err = 2'b00;
        m_hwm = 0;

        // Random mix against the reference stack.
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 19));
            rp = (r < 10) ? 2'd0 : (r < 16) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            rw = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 9) == 0);
            mop(rp, rw, 16'($urandom), rc, $sformatf("rnd%0d", i));
        end
`ifdef RPN_STACK_HWM_EN
        check("rnd.hwm", 32'(hwm), m_hwm);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rpn_stack.md
# rpn_stack

Parametrised operand stack for the RPN calculator datapath. It keeps the top two entries in registers and the rest in a synchronous-read RAM. Each operation pops 0–2 entries and optionally pushes one, which covers a binary-operator result replacing its operands. Illegal operations are rejected and flagged, and an occupancy count is reported. It sits between the UART token decoder/ALU sequencer and the ALU operand inputs.

## Interface
- DATA_W, 16, entry width in bits
- ADDR_W, 5, stack address width
- DEPTH, 2**ADDR_W, maximum number of entries; every entry is usable
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- op_valid  in  1  operation request
- op_ready  out  1  block can accept an operation; an operation is accepted when op_valid && op_ready at the clock edge
- pop_cnt  in  2  entries to pop; values 0–2 only, 3 is treated as an underflow error
- wen  in  1  push din after popping
- din  in  DATA_W  value to push
- first  out  DATA_W  top of stack; 0 when count==0
- second  out  DATA_W  entry below top; 0 when count<2
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err  out  1  sticky error flag
- err_code  out  2  sticky cause: bit0 underflow, bit1 overflow
- err_clr  in  1  clears err and err_code

## Operation
- Let c = current count, p = pop_cnt, w = wen. The new count is c' = c − p + w.
- **Underflow:** p > c, or p==3. The operation is rejected with no state change and sets err_code[0].
- **Overflow:** c' > DEPTH. The operation is rejected with no state change and sets err_code[1].
- err = |err_code.
- If an error occurs in the same cycle as err_clr, the error wins.
- A rejected operation still counts as accepted and does not stall.
- Cache registers always hold the top min(c,2) logical entries. RAM slot i holds logical entry i for i < c−2.
- **Push, no pop (p=0, w=1):**
  - if c≥2, RAM[c−2] ← second
  - second ← first
  - first ← din
  - no refill
- **p=1, w=1:** first ← din; no refill.
- **p=1, w=0:** first ← second; second is refilled from RAM[c−3] if c≥3.
- **p=2, w=1:** first ← din; second is refilled from RAM[c−3] if c≥3.
- **p=2, w=0:** first and second are refilled from RAM[c−3] and RAM[c−4] where those entries exist.
- **p=0, w=0:** no-op; count unchanged.
- FSM states:
  - IDLE: op_ready=1
  - REFILL1: one read pending
  - REFILL2: two reads pending
  - From IDLE, an accepted operation needing k RAM reads goes to REFILL(k). REFILL2 → REFILL1 → IDLE.
- Refill never overlaps a RAM write. Pushes happen only in IDLE.

## Timing
- Reset values: first=0, second=0, count=0, empty=1, full=0, err=0, err_code=0, op_ready=1, state=IDLE. RAM contents are not cleared.
- count, empty, full, err and err_code update on the accepting edge.
- first and second are final on the accepting edge when k=0.
- Refill timing: the RAM read address is issued at the accepting edge. first/second are final k edges later.
- op_ready is low for exactly k cycles after an accepting edge, so back-to-back operations are possible when k=0.
- Slots not yet refilled read as stale until op_ready rises. Consumers sample operands only when op_ready=1.
- rst_n low in any state, including REFILL, forces the reset values at that edge and abandons pending reads.
- Boundaries:
  - Push at c=DEPTH is an overflow.
  - Pop-2/push-1 at c=DEPTH is legal, giving c'=DEPTH−1.
  - Pop at c=0 is an underflow.
  - RAM addresses never wrap, because rejection happens first.

## Configuration
- Macro: RPN_STACK_HWM_EN.
- Defined:
  - adds output port hwm (ADDR_W+1), the high-water mark of count
  - hwm resets to 0 and updates at the same edge as count
  - hwm is also cleared by err_clr
- Undefined: the hwm port and its register do not exist; all other behaviour is identical.

## Structure
- rpn_stack_pkg holds:
  - the FSM state enum (IDLE, REFILL1, REFILL2)
  - ERR_UNF=2'b01, ERR_OVF=2'b10
  - the refill-count function of (c, p, w)
- Sub-module rpn_stack_ram:
  - DEPTH×DATA_W
  - one synchronous write port
  - one synchronous read port with 1-cycle latency, no reset
- The top level holds the cache registers, count, FSM and error logic.

## Test plan
- Reset, then push 5, 7, 9 → first=9, second=7, count=3, op_ready never low.
- Stack [5,7,9], p=2/w=1 din=16 → first=16, second=5, count=2. op_ready low for 1 cycle.
- Stack [1,2,3,4], p=2/w=0 → op_ready low for 2 cycles, then first=2, second=1, count=2.
- Empty stack, p=1 → err=1, err_code=01, count stays 0. err_clr and a second underflow in the same cycle → err stays 1.
- Fill to DEPTH=32, then push → err_code=10, count=32. Then p=2/w=1 → count=31, no new error.
- rst_n low during REFILL2 → next cycle count=0, op_ready=1, first=0. With RPN_STACK_HWM_EN, hwm=0 after reset and equals the peak count after the fill test.
